// File: rtl/seq_divider.sv
// Iterative restoring divider producing one quotient bit per clock.
// A valid/ready handshake is used on both sides. An optional per-transaction
// two's-complement mode divides magnitudes and fixes up the signs at the end.
// Division by zero retires early with an all-ones quotient and the dividend
// as the remainder.
module seq_divider #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] rem_reg, quo_reg, dvs_reg;
  logic             neg_q_reg, neg_r_reg;
  logic [WIDTH-1:0] quotient_reg, remainder_reg;
  logic             dbz_reg, out_valid_reg;

  // Operand conditioning at the accept edge.
  logic             accept, sgn, neg_dvd, neg_dvs, dvs_zero;
  logic [WIDTH-1:0] mag_dvd, mag_dvs;

  assign accept   = (state_reg == IDLE) && in_valid;
  assign sgn      = in_signed & SIGNED_EN;
  assign neg_dvd  = sgn & dividend[WIDTH-1];
  assign neg_dvs  = sgn & divisor[WIDTH-1];
  // The most-negative value negates to itself, which read as unsigned is
  // exactly its magnitude 2^(WIDTH-1).
  assign mag_dvd  = neg_dvd ? -dividend : dividend;
  assign mag_dvs  = neg_dvs ? -divisor  : divisor;
  assign dvs_zero = (divisor == '0);

  // One restoring step: shift {rem,quo} left, then trial-subtract the divisor.
  // The shifted remainder needs WIDTH+1 bits, and one more bit catches the borrow.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_next, quo_next;

  assign rem_sh   = {rem_reg, quo_reg[WIDTH-1]};
  assign diff     = {1'b0, rem_sh} - {2'b00, dvs_reg};
  assign borrow   = diff[WIDTH+1];
  assign rem_next = borrow ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_next = {quo_reg[WIDTH-2:0], ~borrow};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = dvs_zero ? DONE : CALC;
      CALC: if (cnt_reg == '0) state_next = DONE;
      DONE: if (out_valid_reg && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands, iterate, and load the registered results.
  // A divide-by-zero enters DONE with out_valid still low. Its result loads
  // on the following edge, so it appears one cycle after the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      dvs_reg       <= '0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            // A zero divisor keeps the raw dividend as the future remainder.
            rem_reg   <= dvs_zero ? dividend : '0;
            quo_reg   <= mag_dvd;
            dvs_reg   <= mag_dvs;
            cnt_reg   <= CW'(WIDTH - 1);
            neg_q_reg <= neg_dvd ^ neg_dvs;
            neg_r_reg <= neg_dvd;
          end
        end
        CALC: begin
          rem_reg <= rem_next;
          quo_reg <= quo_next;
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == '0) begin
            quotient_reg  <= neg_q_reg ? -quo_next : quo_next;
            remainder_reg <= neg_r_reg ? -rem_next : rem_next;
            dbz_reg       <= 1'b0;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (!out_valid_reg) begin
            quotient_reg  <= '1;
            remainder_reg <= rem_reg;
            dbz_reg       <= 1'b1;
            out_valid_reg <= 1'b1;
          end else if (out_ready) begin
            out_valid_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (state_reg == IDLE);
  assign busy        = (state_reg != IDLE);
  assign out_valid   = out_valid_reg;
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule
